lsu_ctrl: RTL

Load/store initiator between the RV32IM core's execute stage and the data memory port (`MemRW`, `addr`, `dataW`, `MemWriteMask`, `dataR`). It accepts one load/store request per handshake and produces memory cycles with the correct word address, byte mask and lane-shifted write data. Misaligned halfword and word accesses are split into two word cycles. Load data is extracted, merged and sign- or zero-extended before a one-cycle response to the core.

---
 rtl/rv_mem_pkg.sv | 45 ++++
 rtl/lsu_align.sv | 65 ++++++
 rtl/lsu_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared constants for the load/store unit.
//   - RV32 load/store funct3 encodings
//   - access size encodings (funct3[1:0]) and their byte masks
//   - FSM state encodings for lsu_ctrl
package rv_mem_pkg;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   // Access size, taken from funct3[1:0]
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   // FSM states
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ACC0 = 2'd1;
   localparam state_t ST_ACC1 = 2'd2;
   localparam state_t ST_RESP = 2'd3;

   // Right-aligned byte mask for an access size; 0 for the reserved size.
   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      logic [3:0] m;
      case (sz)
         SZ_BYTE: m = 4'b0001;
         SZ_HALF: m = 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   Inputs : we_i (store), funct3_i, k_i (byte offset), wdata_i (right-aligned
//            store data), lo_i / hi_i (captured load words).
//   Outputs: mask0_o / mask1_o (byte enables for Word0 / Word1),
//            wdata0_o / wdata1_o (lane-shifted store data for Word0 / Word1),
//            split_o (access spans two words), illegal_o (bad funct3),
//            rdata_o (merged and extended load result).
module lsu_align
   import rv_mem_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  k_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] lo_i,
   input  logic [31:0] hi_i,
   output logic [3:0]  mask0_o,
   output logic [3:0]  mask1_o,
   output logic [31:0] wdata0_o,
   output logic [31:0] wdata1_o,
   output logic        split_o,
   output logic        illegal_o,
   output logic [31:0] rdata_o
);

   logic [1:0]  size;
   logic [7:0]  mask_wide;
   logic [63:0] wdata_wide;
   logic [63:0] merged;

   assign size = funct3_i[1:0];

   // Shifting into a double-width vector yields both words at once: the low
   // half is the Word0 lanes, the bits pushed past lane 3 land in the high
   // half and are exactly the Word1 lanes (mask >> (4-k), data >> (32-8k)).
   assign mask_wide  = {4'b0000, size_mask(size)} << k_i;
   assign wdata_wide = {32'h0, wdata_i} << {k_i, 3'b000};
   assign mask0_o    = mask_wide[3:0];
   assign mask1_o    = mask_wide[7:4];
   assign wdata0_o   = wdata_wide[31:0];
   assign wdata1_o   = wdata_wide[63:32];

   assign split_o = ((size == SZ_HALF) && (k_i == 2'd3)) ||
                    ((size == SZ_WORD) && (k_i != 2'd0));

   assign illegal_o = we_i ? (funct3_i > F3_SW)
                           : ((funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7));

   // Load data: bring the addressed byte down to bit 0 across both words.
   assign merged = {hi_i, lo_i} >> {k_i, 3'b000};

   always_comb begin
      // NOTE: every path of a combinational block assigns its outputs (here via
      // the default arm) so no latch is inferred.
      case (funct3_i)
         F3_LB:   rdata_o = {{24{merged[7]}}, merged[7:0]};
         F3_LH:   rdata_o = {{16{merged[15]}}, merged[15:0]};
         F3_LW:   rdata_o = merged[31:0];
         F3_LBU:  rdata_o = {24'h0, merged[7:0]};
         F3_LHU:  rdata_o = {16'h0, merged[15:0]};
         default: rdata_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator between the execute stage and data memory.
//   Core side  : req_valid/req_ready handshake with req_we, req_funct3,
//                req_addr, req_wdata; one-cycle resp_valid with resp_rdata
//                and resp_fault.
//   Memory side: MemRW, addr (word aligned), dataW, MemWriteMask, and the
//                asynchronous read data dataR.
//   MISALIGN_EN: 1 splits word-crossing accesses into two cycles, 0 faults them.
module lsu_ctrl
   import rv_mem_pkg::*;
#(
   parameter bit MISALIGN_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        MemRW,
   output logic [31:0] addr,
   output logic [31:0] dataW,
   output logic [3:0]  MemWriteMask,
   input  logic [31:0] dataR
);

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        fault_q, fault_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;

   // Alignment logic sees the live request while idle (to classify it before
   // latching) and the latched request in every other state.
   logic        sel_we;
   logic [2:0]  sel_funct3;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  mask0, mask1;
   logic [31:0] wdata0, wdata1;
   logic        split, illegal;
   logic [31:0] ld_rdata;
   logic [31:0] word0;

   assign sel_we     = (state_q == ST_IDLE) ? req_we     : we_q;
   assign sel_funct3 = (state_q == ST_IDLE) ? req_funct3 : funct3_q;
   assign sel_addr   = (state_q == ST_IDLE) ? req_addr   : addr_q;
   assign sel_wdata  = (state_q == ST_IDLE) ? req_wdata  : wdata_q;

   lsu_align u_align (
      .we_i      (sel_we),
      .funct3_i  (sel_funct3),
      .k_i       (sel_addr[1:0]),
      .wdata_i   (sel_wdata),
      .lo_i      (lo_q),
      .hi_i      (hi_q),
      .mask0_o   (mask0),
      .mask1_o   (mask1),
      .wdata0_o  (wdata0),
      .wdata1_o  (wdata1),
      .split_o   (split),
      .illegal_o (illegal),
      .rdata_o   (ld_rdata)
   );

   assign word0 = {addr_q[31:2], 2'b00};

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      fault_d  = fault_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               fault_d  = illegal || (split && !MISALIGN_EN);
               state_d  = fault_d ? ST_RESP : ST_ACC0;
            end
         end
         ST_ACC0: begin
            if (!we_q) lo_d = dataR;
            state_d = split ? ST_ACC1 : ST_RESP;
         end
         ST_ACC1: begin
            if (!we_q) hi_d = dataR;
            state_d = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         fault_q  <= 1'b0;
         lo_q     <= 32'h0;
         hi_q     <= 32'h0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         fault_q  <= fault_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
      end
   end

   // Outputs decode straight from the state, so reset alone forces them idle.
   always_comb begin
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_rdata   = 32'h0;
      resp_fault   = 1'b0;
      MemRW        = 1'b0;
      addr         = 32'h0;
      dataW        = 32'h0;
      MemWriteMask = 4'b0000;
      case (state_q)
         ST_IDLE: req_ready = 1'b1;
         ST_ACC0: begin
            addr         = word0;
            MemRW        = we_q;
            MemWriteMask = we_q ? mask0 : 4'b0000;
            dataW        = we_q ? wdata0 : 32'h0;
         end
         ST_ACC1: begin
            addr         = word0 + 32'd4;  // wraps modulo 2^32
            MemRW        = we_q;
            MemWriteMask = we_q ? mask1 : 4'b0000;
            dataW        = we_q ? wdata1 : 32'h0;
         end
         default: begin
            resp_valid = 1'b1;
            resp_fault = fault_q;
            resp_rdata = (fault_q || we_q) ? 32'h0 : ld_rdata;
         end
      endcase
   end

endmodule
